// File: rtl/phy_pkg.sv
// Shared PHY definitions: comma symbol, deserializer FSM encoding and the
// layout of the 9-bit {valid, data} word passed to the byte un-striper.
package phy_pkg;

    localparam logic [7:0] COM_SYM   = 8'hBC;
    localparam int         VALID_BIT = 8;
    localparam int         DATA_MSB  = 7;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } rx_state_e;

    function automatic logic [VALID_BIT:0] make_word(input logic valid, input logic [DATA_MSB:0] data);
        logic [VALID_BIT:0] word;
        word                = '0;
        word[VALID_BIT]     = valid;
        word[DATA_MSB:0]    = data;
        return word;
    endfunction

endpackage

// File: rtl/serial_paralelo_rx_com_detect.sv
// Serial shift register and comma matcher: presents the 8 most recent bits
// (including the bit on the wire right now) and flags when they equal COM.
module com_detect
    import phy_pkg::*;
#(
    parameter logic [7:0] COM = COM_SYM
) (
    input  logic       clk8f_i,
    input  logic       reset_n_i,
    input  logic       serial_i,
    output logic [7:0] window_o,
    output logic       com_hit_o
);

    // The oldest bit of the register would fall off the window on the next
    // edge anyway, so only the 7 newest bits are kept.
    logic [6:0] shift_q;
    logic [6:0] shift_d;

    assign window_o  = {shift_q, serial_i};
    assign com_hit_o = (window_o == COM);
    assign shift_d   = window_o[6:0];

    always_ff @(posedge clk8f_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/serial_paralelo_rx.sv
// Receive deserializer: finds byte boundaries by locking onto repeated COM
// symbols, then emits one {valid, data} word per received byte.
module serial_paralelo_rx
    import phy_pkg::*;
#(
    parameter logic [7:0] COM        = COM_SYM,
    parameter int         N_COM_LOCK = 4,
    parameter int         CNT_W      = 3
) (
    input  logic       clk8f,
    input  logic       reset,
    input  logic       serial_in,
    output logic [8:0] paralelo,
    output logic       byte_strobe,
    output logic       active
);

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(N_COM_LOCK - 1);

    rx_state_e        state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] com_cnt_q, com_cnt_d;
    logic [8:0]       paralelo_q, paralelo_d;
    logic             strobe_q, strobe_d;
    logic             active_q, active_d;

    logic [7:0]       window;
    logic             com_hit;
    logic             boundary;

    com_detect #(
        .COM (COM)
    ) u_com_detect (
        .clk8f_i   (clk8f),
        .reset_n_i (reset),
        .serial_i  (serial_in),
        .window_o  (window),
        .com_hit_o (com_hit)
    );

    assign boundary = (bit_cnt_q == 3'd7);

    always_ff @(posedge clk8f or negedge reset) begin
        if (!reset) begin
            state_q    <= SEARCH;
            bit_cnt_q  <= '0;
            com_cnt_q  <= '0;
            paralelo_q <= '0;
            strobe_q   <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            com_cnt_q  <= com_cnt_d;
            paralelo_q <= paralelo_d;
            strobe_q   <= strobe_d;
            active_q   <= active_d;
        end
    end

    // A COM found while searching defines the boundary: resetting bit_cnt on
    // that edge makes every 8th edge after it a boundary.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q + 3'd1;
        com_cnt_d  = com_cnt_q;
        paralelo_d = paralelo_q;
        strobe_d   = 1'b0;
        active_d   = active_q;

        case (state_q)
            SEARCH: begin
                bit_cnt_d = '0;
                if (com_hit) begin
                    com_cnt_d = CNT_W'(1);
                    state_d   = ALIGN;
                end
            end
            ALIGN: begin
                if (boundary) begin
                    if (com_hit) begin
                        if (com_cnt_q == LOCK_LAST) begin
                            state_d  = ACTIVE;
                            active_d = 1'b1;
                        end else begin
                            com_cnt_d = com_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        com_cnt_d = '0;
                        bit_cnt_d = '0;
                        state_d   = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                if (boundary) begin
                    strobe_d   = 1'b1;
                    paralelo_d = com_hit ? make_word(1'b0, COM) : make_word(1'b1, window);
                end
            end
            default: begin
                state_d   = SEARCH;
                bit_cnt_d = '0;
                com_cnt_d = '0;
            end
        endcase
    end

    assign paralelo    = paralelo_q;
    assign byte_strobe = strobe_q;
    assign active      = active_q;

endmodule
